// File: rtl/wb_node_pkg.sv
// Shared types and defaults for the two-master Wishbone node arbiter.
// Holds the arbiter state encoding, the one-hot grant codes and the parameter defaults.
package wb_node_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GNT0 = 2'd1,
        ST_GNT1 = 2'd2,
        ST_ERR  = 2'd3
    } state_t;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_M0   = 2'b01;
    localparam logic [1:0] GRANT_M1   = 2'b10;

    localparam int DEF_AW      = 32;
    localparam int DEF_DW      = 32;
    localparam int DEF_TIMEOUT = 255;

endpackage

// File: rtl/wb_node_wdog.sv
// Stall watchdog: counts consecutive stalled strobe cycles and flags expiry
// on the cycle whose increment would reach TIMEOUT.
module wb_node_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_count_en,
    output logic o_expire
);

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (i_clear) begin
            r_cnt <= 8'd0;
        end else if (i_count_en) begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // A clear in the same cycle (e.g. ack) always beats expiry.
    assign o_expire = i_count_en && !i_clear && (r_cnt == LAST);

endmodule

// File: rtl/wb_node_arbiter.sv
// Round-robin arbiter sharing one Wishbone slave between the management bus (M0)
// and a debug master (M1); grants are held for the whole cycle, stalls time out with err.
module wb_node_arbiter
    import wb_node_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,

    output logic [1:0]      grant_o,
    output logic            busy_o,
    output logic            timeout_o
);

    state_t r_state;
    logic   r_last_grant;   // 0 = M0 served last, 1 = M1 served last
    logic   w_expire;
    logic   w_wdog_clear;

    assign w_wdog_clear = (r_state == ST_IDLE) || s_ack_i || !s_stb_o;

    wb_node_wdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk        (wb_clk_i),
        .rst        (wb_rst_i),
        .i_clear    (w_wdog_clear),
        .i_count_en (s_stb_o),
        .o_expire   (w_expire)
    );

    // Expiry takes priority over cyc falling so the err pulse is never lost.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state      <= ST_IDLE;
            r_last_grant <= 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (m0_cyc_i && m1_cyc_i) begin
                        r_state <= r_last_grant ? ST_GNT0 : ST_GNT1;
                    end else if (m0_cyc_i) begin
                        r_state <= ST_GNT0;
                    end else if (m1_cyc_i) begin
                        r_state <= ST_GNT1;
                    end
                end
                ST_GNT0: begin
                    if (w_expire) begin
                        r_state      <= ST_ERR;
                        r_last_grant <= 1'b0;
                    end else if (!m0_cyc_i) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= 1'b0;
                    end
                end
                ST_GNT1: begin
                    if (w_expire) begin
                        r_state      <= ST_ERR;
                        r_last_grant <= 1'b1;
                    end else if (!m1_cyc_i) begin
                        r_state      <= ST_IDLE;
                        r_last_grant <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // In ERR, r_last_grant already names the master whose cycle timed out.
    always_comb begin
        s_cyc_o   = 1'b0;
        s_stb_o   = 1'b0;
        s_we_o    = 1'b0;
        s_sel_o   = '0;
        s_adr_o   = '0;
        s_dat_o   = '0;
        m0_dat_o  = '0;
        m0_ack_o  = 1'b0;
        m0_err_o  = 1'b0;
        m1_dat_o  = '0;
        m1_ack_o  = 1'b0;
        m1_err_o  = 1'b0;
        grant_o   = GRANT_NONE;
        busy_o    = 1'b0;
        timeout_o = 1'b0;
        case (r_state)
            ST_GNT0: begin
                s_cyc_o  = m0_cyc_i;
                s_stb_o  = m0_stb_i;
                s_we_o   = m0_we_i;
                s_sel_o  = m0_sel_i;
                s_adr_o  = m0_adr_i;
                s_dat_o  = m0_dat_i;
                m0_ack_o = s_ack_i;
                m0_dat_o = s_dat_i;
                grant_o  = GRANT_M0;
                busy_o   = 1'b1;
            end
            ST_GNT1: begin
                s_cyc_o  = m1_cyc_i;
                s_stb_o  = m1_stb_i;
                s_we_o   = m1_we_i;
                s_sel_o  = m1_sel_i;
                s_adr_o  = m1_adr_i;
                s_dat_o  = m1_dat_i;
                m1_ack_o = s_ack_i;
                m1_dat_o = s_dat_i;
                grant_o  = GRANT_M1;
                busy_o   = 1'b1;
            end
            ST_ERR: begin
                m0_err_o  = !r_last_grant;
                m1_err_o  = r_last_grant;
                timeout_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_wb_node_arbiter.sv
// Directed bench for wb_node_arbiter: a vector table for arbitration and data routing,
// plus hand sequences for timeout, ack-beats-timeout and asynchronous reset.
module tb_wb_node_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    localparam logic [31:0] ADR0 = 32'h3000_0004;
    localparam logic [31:0] ADR1 = 32'h3000_0100;
    localparam logic [31:0] DAT0 = 32'hDEAD_BEEF;
    localparam logic [31:0] DAT1 = 32'h0000_0011;

    logic          clk;
    logic          rst;
    logic          m0_cyc, m0_stb, m0_we, m0_ack, m0_err;
    logic [3:0]    m0_sel;
    logic [31:0]   m0_adr, m0_wdat, m0_rdat;
    logic          m1_cyc, m1_stb, m1_we, m1_ack, m1_err;
    logic [3:0]    m1_sel;
    logic [31:0]   m1_adr, m1_wdat, m1_rdat;
    logic          s_cyc, s_stb, s_we, s_ack;
    logic [3:0]    s_sel;
    logic [31:0]   s_adr, s_wdat, s_rdat;
    logic [1:0]    grant;
    logic          busy, tmo;

    int n_pass  = 0;
    int n_total = 0;

    wb_node_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
        .wb_clk_i (clk),      .wb_rst_i (rst),
        .m0_cyc_i (m0_cyc),   .m0_stb_i (m0_stb),  .m0_we_i (m0_we),
        .m0_sel_i (m0_sel),   .m0_adr_i (m0_adr),  .m0_dat_i (m0_wdat),
        .m0_dat_o (m0_rdat),  .m0_ack_o (m0_ack),  .m0_err_o (m0_err),
        .m1_cyc_i (m1_cyc),   .m1_stb_i (m1_stb),  .m1_we_i (m1_we),
        .m1_sel_i (m1_sel),   .m1_adr_i (m1_adr),  .m1_dat_i (m1_wdat),
        .m1_dat_o (m1_rdat),  .m1_ack_o (m1_ack),  .m1_err_o (m1_err),
        .s_cyc_o  (s_cyc),    .s_stb_o  (s_stb),   .s_we_o   (s_we),
        .s_sel_o  (s_sel),    .s_adr_o  (s_adr),   .s_dat_o  (s_wdat),
        .s_dat_i  (s_rdat),   .s_ack_i  (s_ack),
        .grant_o  (grant),    .busy_o   (busy),    .timeout_o (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        m0c, m0w, m1c, ack;
        logic [31:0] sdat;
        logic [1:0]  egnt;
        logic        estb, em0ack, em1ack;
        logic [31:0] em0dat, em1dat, eadr, esdo;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic m0c, logic m0w, logic m1c, logic ack, logic [31:0] sdat,
                                logic [1:0] egnt, logic estb, logic em0ack, logic em1ack,
                                logic [31:0] em0dat, logic [31:0] em1dat,
                                logic [31:0] eadr, logic [31:0] esdo);
        vec_t v;
        v.m0c = m0c; v.m0w = m0w; v.m1c = m1c; v.ack = ack; v.sdat = sdat;
        v.egnt = egnt; v.estb = estb; v.em0ack = em0ack; v.em1ack = em1ack;
        v.em0dat = em0dat; v.em1dat = em1dat; v.eadr = eadr; v.esdo = esdo;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    endtask

    task automatic drive(input logic c0, input logic w0, input logic c1,
                         input logic ack, input logic [31:0] dat);
        m0_cyc = c0; m0_stb = c0; m0_we = w0;
        m1_cyc = c1; m1_stb = c1;
        s_ack  = ack; s_rdat = dat;
    endtask

    // Inputs change 1ns after the rising edge; outputs are sampled on the falling edge.
    task automatic step(input logic c0, input logic w0, input logic c1,
                        input logic ack, input logic [31:0] dat);
        @(posedge clk);
        #1 drive(c0, w0, c1, ack, dat);
        @(negedge clk);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"}, 32'(grant), 32'd0);
        chk({tag, "_busy"},  32'(busy),  32'd0);
        chk({tag, "_scyc"},  32'(s_cyc), 32'd0);
        chk({tag, "_sstb"},  32'(s_stb), 32'd0);
        chk({tag, "_sadr"},  s_adr,      32'd0);
        chk({tag, "_m0ack"}, 32'(m0_ack), 32'd0);
        chk({tag, "_m0dat"}, m0_rdat,    32'd0);
        chk({tag, "_m0err"}, 32'(m0_err), 32'd0);
        chk({tag, "_tmo"},   32'(tmo),   32'd0);
    endtask

    initial begin
        rst = 1'b1;
        m0_sel = 4'hF; m0_adr = ADR0; m0_wdat = DAT0;
        m1_sel = 4'h3; m1_adr = ADR1; m1_wdat = DAT1; m1_we = 1'b0;
        drive(0, 0, 0, 0, 32'd0);

        // Contention x2: M0, M1, M0 with one idle cycle between grants.
        vecs.push_back(mk(1,0,1,0,0,       2'b00,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,1,32'hA0,  2'b01,1,1,0,32'hA0,0,ADR0,DAT0));
        vecs.push_back(mk(0,0,1,0,0,       2'b01,0,0,0,0,0,ADR0,DAT0));
        vecs.push_back(mk(1,0,1,0,0,       2'b00,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,1,32'hB0,  2'b10,1,0,1,0,32'hB0,ADR1,DAT1));
        vecs.push_back(mk(1,0,0,0,0,       2'b10,0,0,0,0,0,ADR1,DAT1));
        vecs.push_back(mk(1,0,1,0,0,       2'b00,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,1,32'hA0,  2'b01,1,1,0,32'hA0,0,ADR0,DAT0));
        vecs.push_back(mk(0,0,0,0,0,       2'b01,0,0,0,0,0,ADR0,DAT0));
        vecs.push_back(mk(0,0,0,0,0,       2'b00,0,0,0,0,0,0,0));
        // M0 alone writes DEADBEEF to 0x3000_0004, zero-wait slave.
        vecs.push_back(mk(1,1,0,0,0,       2'b00,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,1,0,1,0,       2'b01,1,1,0,0,0,ADR0,DAT0));
        vecs.push_back(mk(0,0,0,0,0,       2'b01,0,0,0,0,0,ADR0,DAT0));
        vecs.push_back(mk(0,0,0,0,0,       2'b00,0,0,0,0,0,0,0));
        // M1 4-beat block read while M0 waits.
        vecs.push_back(mk(1,0,1,0,0,       2'b00,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,1,32'd1,   2'b10,1,0,1,0,32'd1,ADR1,DAT1));
        vecs.push_back(mk(1,0,1,1,32'd2,   2'b10,1,0,1,0,32'd2,ADR1,DAT1));
        vecs.push_back(mk(1,0,1,1,32'd3,   2'b10,1,0,1,0,32'd3,ADR1,DAT1));
        vecs.push_back(mk(1,0,1,1,32'd4,   2'b10,1,0,1,0,32'd4,ADR1,DAT1));
        vecs.push_back(mk(1,0,0,0,0,       2'b10,0,0,0,0,0,ADR1,DAT1));
        vecs.push_back(mk(1,0,0,0,0,       2'b00,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1,32'h55,  2'b01,1,1,0,32'h55,0,ADR0,DAT0));
        vecs.push_back(mk(0,0,0,0,0,       2'b01,0,0,0,0,0,ADR0,DAT0));
        vecs.push_back(mk(0,0,0,0,0,       2'b00,0,0,0,0,0,0,0));

        #3 chk_all_zero("reset");
        chk("reset_m1ack", 32'(m1_ack), 32'd0);
        chk("reset_m1err", 32'(m1_err), 32'd0);
        #4 rst = 1'b0;

        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            step(v.m0c, v.m0w, v.m1c, v.ack, v.sdat);
            chk($sformatf("v%0d_grant", i), 32'(grant),  32'(v.egnt));
            chk($sformatf("v%0d_busy", i),  32'(busy),   32'(v.egnt != 2'b00));
            chk($sformatf("v%0d_sstb", i),  32'(s_stb),  32'(v.estb));
            chk($sformatf("v%0d_m0ack", i), 32'(m0_ack), 32'(v.em0ack));
            chk($sformatf("v%0d_m1ack", i), 32'(m1_ack), 32'(v.em1ack));
            chk($sformatf("v%0d_m0dat", i), m0_rdat,     v.em0dat);
            chk($sformatf("v%0d_m1dat", i), m1_rdat,     v.em1dat);
            chk($sformatf("v%0d_sadr", i),  s_adr,       v.eadr);
            chk($sformatf("v%0d_sdo", i),   s_wdat,      v.esdo);
            if (i == 11) begin
                chk("wr_swe", 32'(s_we), 32'd1);
                chk("wr_ssel", 32'(s_sel), 32'hF);
            end
        end

        // Slave never acks: err and timeout pulse after 16 stalled cycles.
        step(1, 0, 0, 0, 0);
        for (int j = 1; j <= TO; j++) begin
            step(1, 0, 0, 0, 0);
            chk($sformatf("to_stall%0d_scyc", j), 32'(s_cyc), 32'd1);
            chk($sformatf("to_stall%0d_tmo", j),  32'(tmo),   32'd0);
            chk($sformatf("to_stall%0d_err", j),  32'(m0_err), 32'd0);
        end
        step(0, 0, 0, 0, 0);
        chk("to_err_tmo",   32'(tmo),    32'd1);
        chk("to_err_m0err", 32'(m0_err), 32'd1);
        chk("to_err_m1err", 32'(m1_err), 32'd0);
        chk("to_err_scyc",  32'(s_cyc),  32'd0);
        chk("to_err_grant", 32'(grant),  32'd0);
        step(1, 0, 0, 0, 0);
        chk("to_after_tmo", 32'(tmo),    32'd0);
        chk("to_after_err", 32'(m0_err), 32'd0);
        step(1, 0, 0, 1, 32'h77);
        chk("to_regrant_grant", 32'(grant), 32'b01);
        chk("to_regrant_ack",   32'(m0_ack), 32'd1);
        chk("to_regrant_dat",   m0_rdat,     32'h77);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);

        // Ack arrives in the cycle the counter would expire: ack wins.
        step(1, 0, 0, 0, 0);
        for (int j = 1; j < TO; j++) begin
            step(1, 0, 0, 0, 0);
            chk($sformatf("race_stall%0d_ack", j), 32'(m0_ack), 32'd0);
        end
        step(1, 0, 0, 1, 32'h66);
        chk("race_ack",    32'(m0_ack), 32'd1);
        chk("race_dat",    m0_rdat,     32'h66);
        chk("race_tmo",    32'(tmo),    32'd0);
        step(0, 0, 0, 0, 0);
        chk("race_post_tmo",   32'(tmo),    32'd0);
        chk("race_post_err",   32'(m0_err), 32'd0);
        chk("race_post_grant", 32'(grant),  32'b01);
        step(0, 0, 0, 0, 0);
        chk("race_idle_grant", 32'(grant), 32'd0);

        // Asynchronous reset mid-transfer, then contention goes to M0.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        chk("ar_pre_grant", 32'(grant), 32'b01);
        @(posedge clk);
        #1 drive(1, 0, 1, 1, 32'h99);
        #1 chk("ar_pre_ack", 32'(m0_ack), 32'd1);
        #1 rst = 1'b1;
        #1 chk_all_zero("ar");
        chk("ar_m1ack", 32'(m1_ack), 32'd0);
        #1 rst = 1'b0;
        s_ack = 1'b0;
        step(1, 0, 1, 0, 0);
        chk("ar_first_grant", 32'(grant), 32'b01);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        chk("ar_gap_grant", 32'(grant), 32'd0);
        step(0, 0, 1, 0, 0);
        chk("ar_second_grant", 32'(grant), 32'b10);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("ar_end_grant", 32'(grant), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_node_arbiter.md
# wb_node_arbiter

Two-master Wishbone arbiter that shares the user project's single internal Wishbone slave port between the Caravel management-SoC bus (M0, `wbs_*` side) and a logic-analyzer-driven debug master (M1). It sits between the user-project wrapper's Wishbone pins and the node register block. It provides round-robin grant, holds the grant for a whole bus cycle, and has a stall timeout that returns an error so a hung slave cannot lock up the management core.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width (multiple of 8)
- `TIMEOUT`, 255, cycles of `s_stb_o` without `s_ack_i` before error (1..255)

Ports:
- `wb_clk_i` in 1: single clock
- `wb_rst_i` in 1: reset, asynchronous, active-high
- `mN_cyc_i`, `mN_stb_i`, `mN_we_i` in 1 each, N=0,1: master cycle/strobe/write
- `mN_sel_i` in DW/8: byte selects
- `mN_adr_i` in AW: address
- `mN_dat_i` in DW: write data
- `mN_dat_o` out DW: read data
- `mN_ack_o`, `mN_err_o` out 1 each: terminations
- `s_cyc_o`, `s_stb_o`, `s_we_o` out 1 each; `s_sel_o` out DW/8; `s_adr_o` out AW; `s_dat_o` out DW: to slave
- `s_dat_i` in DW; `s_ack_i` in 1: from slave
- `grant_o` out 2: one-hot current grant (00 = none)
- `busy_o` out 1: a grant is held
- `timeout_o` out 1: one-cycle pulse on timeout

## Operation
- FSM states: IDLE, GNT0, GNT1, ERR. Reset state IDLE; `last_grant` resets to M1, so M0 wins the first contention.
- IDLE: no request -> stay. Only one `mN_cyc_i` high -> GNTN. Both high -> grant the master that is not `last_grant`.
- GNTN: slave outputs mux from master N. `s_cyc_o`=`mN_cyc_i`, `s_stb_o`=`mN_stb_i`. `s_ack_i` routes only to `mN_ack_o`. `s_dat_i` routes only to `mN_dat_o`.
- GNTN: the grant is held while `mN_cyc_i`=1, so block/burst cycles are never split. When `mN_cyc_i` falls -> IDLE and `last_grant`<=N.
- Timeout counter (8 bit) clears in IDLE, on `s_ack_i`, and whenever `s_stb_o`=0. It increments otherwise. When the count reaches `TIMEOUT`: go to ERR and raise `timeout_o`.
- ERR (one cycle): `s_cyc_o`=`s_stb_o`=0, `mN_err_o`=1 for the granted master only, `last_grant`<=N. Then -> IDLE.
- Signals of the non-granted master, and of both masters in IDLE: `ack`/`err`=0, `dat_o`=0.
- All `s_*` outputs are 0 in IDLE and ERR.
- Reset value of every output is 0, including `grant_o`=00.

## Timing
- Arbitration latency: request seen in IDLE at cycle k; grant registered and `s_stb_o` driven at k+1.
- No added ack latency: `mN_ack_o` is combinational from `s_ack_i` in the same cycle.
- A zero-wait slave therefore completes a single transfer at k+1.
- Exactly one idle cycle separates consecutive grants, including re-grant of the same master.
- Simultaneous `s_ack_i` and counter reaching `TIMEOUT`: the ack wins, the counter clears, and there is no error.
- `mN_cyc_i` falling in the same cycle the timeout fires: ERR is still entered and the err pulse is issued.
- Asynchronous reset mid-transfer: outputs go to 0 immediately without waiting for a clock edge, the FSM returns to IDLE, and `last_grant` returns to M1. No ack is issued for the aborted cycle.

## Structure
- Package `wb_node_pkg` holds:
  - the state enum (IDLE/GNT0/GNT1/ERR),
  - grant one-hot constants,
  - default `AW`/`DW`/`TIMEOUT` localparams.
- One sub-module, `wb_node_wdog`, contains the stall counter. Inputs: clear, count-enable. Output: expire. It takes `TIMEOUT` as a parameter.
- Muxes and the FSM live in the top level.

## Test plan
- M0 alone writes 0xDEADBEEF to 0x3000_0004 with a zero-wait slave: `grant_o`=01 one cycle after `cyc`, `m0_ack_o` in that cycle, slave sees the data, `m1_ack_o` never rises.
- M0 and M1 request in the same cycle, twice back-to-back: grant order M0, M1, M0 with one idle cycle between grants.
- M1 holds `cyc` for a 4-beat block read (slave returns 1,2,3,4) while M0 requests: M0 is not granted until M1 drops `cyc`. M1 receives 1..4 in order.
- Slave never acks with `TIMEOUT`=16: `timeout_o` and `m0_err_o` pulse after 16 stalled cycles, `s_cyc_o` drops, the next request is granted normally.
- Slave acks in the same cycle the counter hits 16: normal ack, no `err`, no `timeout_o`.
- Assert `wb_rst_i` asynchronously between clock edges mid-transfer: all outputs are 0 before the next edge. After release, a contention is granted to M0 first.
